// File: rtl/rvc_pkg.sv
// Shared RV32I / RVC encoding constants and the pack-buffer state type
// used by the compressor and the word packer.
package rvc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] CQ0 = 2'b00;
  localparam logic [1:0] CQ1 = 2'b01;
  localparam logic [1:0] CQ2 = 2'b10;

  localparam logic [2:0] CF3_ADDI = 3'b000;
  localparam logic [2:0] CF3_LI   = 3'b010;
  localparam logic [2:0] CF3_LUI  = 3'b011;
  localparam logic [2:0] CF3_MISC = 3'b100;
  localparam logic [2:0] CF3_LW   = 3'b010;
  localparam logic [2:0] CF3_SW   = 3'b110;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic {EMPTY, HALF} pack_state_t;

  function automatic logic is_primed(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  function automatic logic fits_simm6(input logic [11:0] imm);
    return (imm[11:5] == 7'h00) || (imm[11:5] == 7'h7F);
  endfunction

endpackage

// File: rtl/rvc_compressor_packer_if.sv
// Instruction, flush and packed-word handshakes of the compressor/packer.
interface rvc_compressor_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush_valid;
  logic        flush_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;

  modport master (
    output in_valid, in_instr, flush_valid, out_ready,
    input  in_ready, flush_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_instr, flush_valid, out_ready,
    output in_ready, flush_ready, out_valid, out_word
  );
endinterface

// File: rtl/rvc_compressor.sv
// Combinational RV32I -> RVC encoder; ok=0 means the instruction has no
// 16-bit equivalent and must be emitted as-is.
module rvc_compressor
  import rvc_pkg::*;
#(
  parameter int EN_SP_FORMS = 1
) (
  input  logic [31:0] instr,
  output logic [15:0] c16,
  output logic        ok
);

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] imm_i, imm_s;
  logic [19:0] imm_u;
  logic        sp_en, ca_regs;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign funct7  = instr[31:25];
  assign imm_i   = instr[31:20];
  assign imm_s   = {instr[31:25], instr[11:7]};
  assign imm_u   = instr[31:12];
  assign sp_en   = (EN_SP_FORMS != 0);
  assign ca_regs = is_primed(rd) && (rs1 == rd) && is_primed(rs2);

  always_comb begin
    c16 = 16'h0000;
    ok  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        case (funct3)
          F3_ADD: begin
            if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
              c16 = C_NOP;
              ok  = 1'b1;
            end else if (rd != 5'd0 && rs1 == rd && imm_i != 12'd0 && fits_simm6(imm_i)) begin
              c16 = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], CQ1};
              ok  = 1'b1;
            end else if (rd != 5'd0 && rs1 == 5'd0 && fits_simm6(imm_i)) begin
              c16 = {CF3_LI, imm_i[5], rd, imm_i[4:0], CQ1};
              ok  = 1'b1;
            end else if (sp_en && rd == 5'd2 && rs1 == 5'd2 && imm_i != 12'd0 &&
                         imm_i[3:0] == 4'd0 && (imm_i[11:9] == 3'b000 || imm_i[11:9] == 3'b111)) begin
              c16 = {CF3_LUI, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], CQ1};
              ok  = 1'b1;
            end else if (sp_en && rs1 == 5'd2 && is_primed(rd) && imm_i != 12'd0 &&
                         imm_i[1:0] == 2'b00 && imm_i[11:10] == 2'b00) begin
              c16 = {CF3_ADDI, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], CQ0};
              ok  = 1'b1;
            end
          end
          F3_SLL: begin
            if (funct7 == F7_ZERO && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
              c16 = {CF3_ADDI, 1'b0, rd, rs2, CQ2};
              ok  = 1'b1;
            end
          end
          F3_SRL: begin
            if ((funct7 == F7_ZERO || funct7 == F7_ALT) && is_primed(rd) && rs1 == rd && rs2 != 5'd0) begin
              c16 = {CF3_MISC, 1'b0, 1'b0, funct7[5], rd[2:0], rs2, CQ1};
              ok  = 1'b1;
            end
          end
          F3_AND: begin
            if (is_primed(rd) && rs1 == rd && fits_simm6(imm_i)) begin
              c16 = {CF3_MISC, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], CQ1};
              ok  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_ALT && funct3 == F3_ADD && ca_regs) begin
          c16 = {CF3_MISC, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], CQ1};
          ok  = 1'b1;
        end else if (funct7 == F7_ZERO) begin
          case (funct3)
            F3_ADD: begin
              if (rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
                c16 = {CF3_MISC, 1'b0, rd, rs2, CQ2};
                ok  = 1'b1;
              end else if (rd != 5'd0 && rs2 != 5'd0 && rs1 == rd) begin
                c16 = {CF3_MISC, 1'b1, rd, rs2, CQ2};
                ok  = 1'b1;
              end
            end
            F3_XOR, F3_OR, F3_AND: begin
              if (ca_regs) begin
                // funct3 100/110/111 map onto the CA sub-op codes 01/10/11
                c16 = {CF3_MISC, 1'b0, 2'b11, rd[2:0], funct3[1] | ~funct3[0] ? {funct3[1], funct3[0] | ~funct3[1]} : 2'b01, rs2[2:0], CQ1};
                ok  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      OPC_LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && imm_u != 20'd0 &&
            (imm_u[19:5] == 15'h0000 || imm_u[19:5] == 15'h7FFF)) begin
          c16 = {CF3_LUI, imm_u[5], rd, imm_u[4:0], CQ1};
          ok  = 1'b1;
        end
      end
      OPC_JALR: begin
        if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
          c16 = {CF3_MISC, rd[0], rs1, 5'd0, CQ2};
          ok  = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_W && imm_i[1:0] == 2'b00) begin
          if (sp_en && rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0) begin
            c16 = {CF3_LW, imm_i[5], rd, imm_i[4:2], imm_i[7:6], CQ2};
            ok  = 1'b1;
          end else if (is_primed(rs1) && is_primed(rd) && imm_i[11:7] == 5'd0) begin
            c16 = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], CQ0};
            ok  = 1'b1;
          end
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_W && imm_s[1:0] == 2'b00) begin
          if (sp_en && rs1 == 5'd2 && imm_s[11:8] == 4'd0) begin
            c16 = {CF3_SW, imm_s[5:2], imm_s[7:6], rs2, CQ2};
            ok  = 1'b1;
          end else if (is_primed(rs1) && is_primed(rs2) && imm_s[11:7] == 5'd0) begin
            c16 = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], CQ0};
            ok  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvc_compressor_packer.sv
// Compresses an RV32I stream and packs 16/32-bit parcels into little-endian
// 32-bit words through a single-entry output register.
module rvc_compressor_packer
  import rvc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int EN_SP_FORMS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rvc_compressor_packer_if.slave bus,
  output logic                 half_pending,
  output logic [CNT_W-1:0]     cnt_total,
  output logic [CNT_W-1:0]     cnt_compressed
);

  pack_state_t state_reg, state_next;
  logic [15:0] pend_reg, pend_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_word_reg, out_word_next;
  logic [15:0] c16;
  logic        ok;
  logic        slot_free, in_fire, flush_fire;
  logic [1:0]  cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  rvc_compressor #(.EN_SP_FORMS(EN_SP_FORMS)) u_enc (
    .instr (bus.in_instr),
    .c16   (c16),
    .ok    (ok)
  );

  assign slot_free       = !out_valid_reg || bus.out_ready;
  assign bus.in_ready    = slot_free;
  assign bus.flush_ready = slot_free && !bus.in_valid;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_word    = out_word_reg;
  assign in_fire         = bus.in_valid && slot_free;
  assign flush_fire      = bus.flush_valid && slot_free && !bus.in_valid;
  assign half_pending    = (state_reg == HALF);

  always_comb begin
    state_next     = state_reg;
    pend_next      = pend_reg;
    out_valid_next = out_valid_reg && !bus.out_ready;
    out_word_next  = out_word_reg;
    if (in_fire) begin
      if (state_reg == EMPTY) begin
        if (ok) begin
          pend_next  = c16;
          state_next = HALF;
        end else begin
          out_word_next  = bus.in_instr;
          out_valid_next = 1'b1;
        end
      end else begin
        out_valid_next = 1'b1;
        if (ok) begin
          out_word_next = {c16, pend_reg};
          state_next    = EMPTY;
        end else begin
          // the upper half of a straddling 32-bit instruction stays pending
          out_word_next = {bus.in_instr[15:0], pend_reg};
          pend_next     = bus.in_instr[31:16];
        end
      end
    end else if (flush_fire && state_reg == HALF) begin
      out_word_next  = {C_NOP, pend_reg};
      out_valid_next = 1'b1;
      state_next     = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      pend_reg      <= 16'h0000;
      out_valid_reg <= 1'b0;
      out_word_reg  <= 32'h0000_0000;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= pend_next;
      out_valid_reg <= out_valid_next;
      out_word_reg  <= out_word_next;
    end
  end

  assign cnt_inc = {in_fire && ok, in_fire};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && cnt_reg[gi] != {CNT_W{1'b1}}) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt_total      = cnt_reg[0];
  assign cnt_compressed = cnt_reg[1];

endmodule

// File: tb/tb_rvc_compressor_packer.sv
// Directed bench for rvc_compressor_packer: encodings, packing, flush,
// backpressure, counter saturation (4-bit counters) and mid-stream reset.
module tb_rvc_compressor_packer;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic half_pending;
  logic [CNT_W-1:0] cnt_total, cnt_compressed;
  int n_assert = 0;
  int n_fail   = 0;

  rvc_compressor_packer_if bus ();

  rvc_compressor_packer #(.CNT_W(CNT_W), .EN_SP_FORMS(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .half_pending   (half_pending),
    .cnt_total      (cnt_total),
    .cnt_compressed (cnt_compressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    tick();
    bus.in_valid = 1'b0;
    $display("instr 0x%08h -> out_valid=%0b out_word=0x%08h half=%0b total=%0d comp=%0d",
             ins, bus.out_valid, bus.out_word, half_pending, cnt_total, cnt_compressed);
  endtask

  task automatic flush();
    bus.flush_valid = 1'b1;
    tick();
    bus.flush_valid = 1'b0;
    $display("flush -> out_valid=%0b out_word=0x%08h half=%0b",
             bus.out_valid, bus.out_word, half_pending);
  endtask

  task automatic pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_word);
    send(a);
    chk({tag, "_half"}, {31'd0, half_pending}, 32'd1);
    send(b);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_word"}, bus.out_word, exp_word);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_instr    = 32'h0;
    bus.flush_valid = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_word", bus.out_word, 32'h0);
    chk("rst_half", {31'd0, half_pending}, 32'd0);
    chk("rst_total", {28'd0, cnt_total}, 32'd0);
    chk("rst_comp", {28'd0, cnt_compressed}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_flush_ready", {31'd0, bus.flush_ready}, 32'd1);

    // c.addi + c.add in one word
    send(32'h00540413);
    chk("t1_no_out", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_half", {31'd0, half_pending}, 32'd1);
    send(32'h00B50533);
    chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_word", bus.out_word, 32'h952E0415);
    chk("t1_half_clr", {31'd0, half_pending}, 32'd0);
    chk("t1_total", {28'd0, cnt_total}, 32'd2);
    chk("t1_comp", {28'd0, cnt_compressed}, 32'd2);

    send(32'h06440413);
    chk("t2_word", bus.out_word, 32'h06440413);
    chk("t2_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t2_half", {31'd0, half_pending}, 32'd0);

    // straddling 32-bit instruction and flush padding
    send(32'h00540413);
    chk("t3_half_a", {31'd0, half_pending}, 32'd1);
    send(32'h06440413);
    chk("t3_word_a", bus.out_word, 32'h04130415);
    chk("t3_half_b", {31'd0, half_pending}, 32'd1);
    flush();
    chk("t3_word_b", bus.out_word, 32'h00010644);
    chk("t3_half_c", {31'd0, half_pending}, 32'd0);
    chk("t3_total", {28'd0, cnt_total}, 32'd5);
    chk("t3_comp", {28'd0, cnt_compressed}, 32'd3);
    tick();
    chk("idle_drain", {31'd0, bus.out_valid}, 32'd0);
    flush();
    chk("flush_empty_no_out", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_empty_half", {31'd0, half_pending}, 32'd0);

    // pass-through cases
    send(32'h00540410);
    chk("low_bits_pass", bus.out_word, 32'h00540410);
    send(32'h00050463);
    chk("beq_pass", bus.out_word, 32'h00050463);
    send(32'h008000EF);
    chk("jal_pass", bus.out_word, 32'h008000EF);
    chk("pass_total", {28'd0, cnt_total}, 32'd8);
    chk("pass_comp", {28'd0, cnt_compressed}, 32'd3);

    pair("li_lwsp",   32'hFFF00513, 32'h00812503, 32'h4522557D);
    pair("sw_jr",     32'h00942223, 32'h00008067, 32'h8082C044);
    pair("lui_sp16",  32'hFFFFF537, 32'hFC010113, 32'h7139757D);
    pair("spn_srai",  32'h01010413, 32'h40345413, 32'h840D0800);
    chk("sat_total", {28'd0, cnt_total}, 32'd15);
    chk("mid_comp", {28'd0, cnt_compressed}, 32'd11);
    pair("sub_mv",    32'h40940433, 32'h00B00533, 32'h852E8C05);
    pair("slli_nop",  32'h00251513, 32'h00000013, 32'h0001050A);

    // immediate range boundaries
    send(32'hFE040413);
    chk("addi_m32_half", {31'd0, half_pending}, 32'd1);
    send(32'h0804A403);
    chk("lw128_word", bus.out_word, 32'hA4031401);
    send(32'h02040413);
    chk("addi32_word", bus.out_word, 32'h04130804);
    flush();
    chk("bound_flush", bus.out_word, 32'h00010204);
    chk("sat_comp", {28'd0, cnt_compressed}, 32'd15);
    chk("sat_total_hold", {28'd0, cnt_total}, 32'd15);
    tick();

    // backpressure with competing instruction and flush
    bus.out_ready = 1'b0;
    send(32'h06440413);
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_instr    = 32'h00540413;
    bus.flush_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_flush_ready", {31'd0, bus.flush_ready}, 32'd0);
      chk("bp_word_stable", bus.out_word, 32'h06440413);
      $display("stall cycle %0d out_word=0x%08h", i, bus.out_word);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_release_flush_ready", {31'd0, bus.flush_ready}, 32'd0);
    tick();
    bus.in_valid    = 1'b0;
    bus.flush_valid = 1'b0;
    chk("bp_accept_half", {31'd0, half_pending}, 32'd1);
    chk("bp_accept_no_out", {31'd0, bus.out_valid}, 32'd0);

    // reset while a word is stalled in HALF
    bus.out_ready = 1'b0;
    send(32'h06440413);
    tick();
    chk("pre_rst_word", bus.out_word, 32'h04130415);
    chk("pre_rst_half", {31'd0, half_pending}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_half", {31'd0, half_pending}, 32'd0);
    chk("mid_rst_total", {28'd0, cnt_total}, 32'd0);
    chk("mid_rst_comp", {28'd0, cnt_compressed}, 32'd0);
    bus.out_ready = 1'b1;
    send(32'h00540413);
    chk("post_rst_half", {31'd0, half_pending}, 32'd1);
    chk("post_rst_no_out", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_total", {28'd0, cnt_total}, 32'd1);
    chk("post_rst_comp", {28'd0, cnt_compressed}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
